// File: rtl/regfile.sv
// Architectural register file with a write-back hazard scoreboard.
// Two combinational read ports, one write port fed by write-back, and a
// per-register pending bit that decode uses to stall on read-after-write.
// Optional feature macro: REGFILE_BYPASS_EN forwards the in-flight
// write-back data to the read ports and masks the matching pending bit.
// Register address width is `BITS_REGFILE+1, normally supplied by defines.vh.

`ifndef BITS_REGFILE
`define BITS_REGFILE 4
`endif

module regfile #(
  parameter int DataSize = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wreg_i,
  input  logic [`BITS_REGFILE:0]         destination_i,
  input  logic [DataSize-1:0]            datareg_i,
  input  logic [`BITS_REGFILE:0]         rs1_addr_i,
  input  logic [`BITS_REGFILE:0]         rs2_addr_i,
  output logic [DataSize-1:0]            rs1_data_o,
  output logic [DataSize-1:0]            rs2_data_o,
  input  logic                           issue_i,
  input  logic [`BITS_REGFILE:0]         issue_dest_i,
  input  logic                           flush_i,
  output logic                           stall_o,
  output logic [(1<<(`BITS_REGFILE+1))-1:0] pending_o
);

  localparam int AddrW = `BITS_REGFILE + 1;
  localparam int NRegs = 1 << AddrW;

  logic [DataSize-1:0] regs [NRegs];
  logic [NRegs-1:0]    pending_q;
  logic [NRegs-1:0]    pending_d;
  logic                wr_live;
  logic                fwd1;
  logic                fwd2;

  assign wr_live = wreg_i && (destination_i != '0);

  // Register storage: write-back commits on the rising edge, r0 never written.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regs <= '{default: '0};
    end else if (wr_live) begin
      regs[destination_i] <= datareg_i;
    end
  end

  // Scoreboard next state: clear on write-back, then set on issue so the
  // newer producer wins a same-register collision; flush overrides both.
  always_comb begin
    pending_d = pending_q;
    if (wreg_i) begin
      pending_d[destination_i] = 1'b0;
    end
    if (issue_i && (issue_dest_i != '0)) begin
      pending_d[issue_dest_i] = 1'b1;
    end
    if (flush_i) begin
      pending_d = '0;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Forwarding match per read port; only meaningful with bypass compiled in.
  always_comb begin
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
    fwd1 = wr_live && (destination_i == rs1_addr_i);
    fwd2 = wr_live && (destination_i == rs2_addr_i);
`endif
  end

  // Read ports: r0 reads zero; bypass data is gated so reset forces zero.
  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (rst_i) begin
      if (fwd1) begin
        rs1_data_o = datareg_i;
      end else if (rs1_addr_i != '0) begin
        rs1_data_o = regs[rs1_addr_i];
      end
      if (fwd2) begin
        rs2_data_o = datareg_i;
      end else if (rs2_addr_i != '0) begin
        rs2_data_o = regs[rs2_addr_i];
      end
    end
  end

  // Hazard stall: an operand with an outstanding producer not being forwarded.
  always_comb begin
    stall_o = (pending_q[rs1_addr_i] & ~fwd1) | (pending_q[rs2_addr_i] & ~fwd2);
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, hand sequences for
// reset / hazard / collision / flush, then randomized traffic against a model.

`ifndef BITS_REGFILE
`define BITS_REGFILE 4
`endif

module tb_regfile;

  localparam int AW = `BITS_REGFILE + 1;
  localparam int N  = 1 << AW;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          wreg_i;
  logic [AW-1:0] destination_i;
  logic [31:0]   datareg_i;
  logic [AW-1:0] rs1_addr_i;
  logic [AW-1:0] rs2_addr_i;
  logic [31:0]   rs1_data_o;
  logic [31:0]   rs2_data_o;
  logic          issue_i;
  logic [AW-1:0] issue_dest_i;
  logic          flush_i;
  logic          stall_o;
  logic [N-1:0]  pending_o;

  int errors = 0;
  int checks = 0;

  regfile #(.DataSize(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wreg_i(wreg_i), .destination_i(destination_i),
    .datareg_i(datareg_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .issue_i(issue_i),
    .issue_dest_i(issue_dest_i), .flush_i(flush_i), .stall_o(stall_o),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          wreg;
    logic [AW-1:0] dest;
    logic [31:0]   data;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          issue;
    logic [AW-1:0] idest;
    logic [31:0]   e1;
    logic [31:0]   e2;
    logic          es;
    logic [N-1:0]  ep;
  } vec_t;

  vec_t tbl [8];

  // behavioural reference state for the random phase
  logic [31:0] m_regs [N];
  bit          m_pend [N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic w, input int d, input logic [31:0] data,
                       input int r1, input int r2, input logic iss, input int idst,
                       input logic fl);
    wreg_i        = w;
    destination_i = AW'(d);
    datareg_i     = data;
    rs1_addr_i    = AW'(r1);
    rs2_addr_i    = AW'(r2);
    issue_i       = iss;
    issue_dest_i  = AW'(idst);
    flush_i       = fl;
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  function automatic vec_t mk(input logic w, input int d, input logic [31:0] data,
                              input int r1, input int r2, input logic iss, input int idst,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic es, input logic [N-1:0] ep);
    vec_t v;
    v.wreg = w; v.dest = AW'(d); v.data = data; v.rs1 = AW'(r1); v.rs2 = AW'(r2);
    v.issue = iss; v.idest = AW'(idst); v.e1 = e1; v.e2 = e2; v.es = es; v.ep = ep;
    return v;
  endfunction

  initial begin
    logic [N-1:0] exp_pend;
    logic [31:0]  e1, e2;
    logic         es, f1, f2;
    int           a1, a2, d;

    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // reset state
    #2;
    chk("reset_pending", 64'(pending_o), 64'd0);
    chk("reset_stall", 64'(stall_o), 64'd0);
    do_reset();

    // directed table, checked before each rising edge
    tbl[0] = mk(1, 1, 32'h11111111, 2, 0, 0, 0, 32'h0,        32'h0,        0, '0);
    tbl[1] = mk(1, 2, 32'h22222222, 1, 3, 0, 0, 32'h11111111, 32'h0,        0, '0);
    tbl[2] = mk(0, 0, 32'h0,        1, 2, 1, 3, 32'h11111111, 32'h22222222, 0, '0);
    tbl[3] = mk(0, 0, 32'h0,        3, 0, 0, 0, 32'h0,        32'h0,        1, N'(8));
    tbl[4] = mk(1, 3, 32'h33,       4, 1, 0, 0, 32'h0,        32'h11111111, 0, N'(8));
    tbl[5] = mk(0, 0, 32'h0,        3, 3, 0, 0, 32'h33,       32'h33,       0, '0);
    tbl[6] = mk(1, 0, 32'h1234,     0, 0, 1, 0, 32'h0,        32'h0,        0, '0);
    tbl[7] = mk(0, 0, 32'h0,        0, 2, 0, 0, 32'h0,        32'h22222222, 0, '0);
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(tbl[i].wreg, int'(tbl[i].dest), tbl[i].data, int'(tbl[i].rs1),
            int'(tbl[i].rs2), tbl[i].issue, int'(tbl[i].idest), 0);
      #1;
      chk($sformatf("tbl%0d_rs1", i), 64'(rs1_data_o), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d_rs2", i), 64'(rs2_data_o), 64'(tbl[i].e2));
      chk($sformatf("tbl%0d_stall", i), 64'(stall_o), 64'(tbl[i].es));
      chk($sformatf("tbl%0d_pend", i), 64'(pending_o), 64'(tbl[i].ep));
    end

    // mid-run asynchronous reset
    tick(); drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tick(); drive(0, 0, 0, 5, 0, 1, 6, 0);
    #1 chk("rst_pre_r5", 64'(rs1_data_o), 64'hDEADBEEF);
    tick(); drive(0, 0, 0, 5, 6, 0, 0, 0);
    #1 chk("rst_pre_pend", 64'(pending_o), 64'(N'(1) << 6));
    rst_i = 1'b0;
    drive(1, 5, 32'hCAFE, 5, 6, 1, 6, 0);
    #1;
    chk("rst_rs1", 64'(rs1_data_o), 64'd0);
    chk("rst_pend", 64'(pending_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    tick(); #1;
    chk("rst_hold_rs1", 64'(rs1_data_o), 64'd0);
    chk("rst_hold_pend", 64'(pending_o), 64'd0);
    tick(); rst_i = 1'b1; drive(0, 0, 0, 5, 0, 0, 0, 0);
    #1 chk("rst_after_r5", 64'(rs1_data_o), 64'd0);

    // write / read, with same-cycle visibility only under bypass
    tick(); drive(1, 3, 32'h1, 0, 0, 0, 0, 0);
    tick(); drive(1, 3, 32'hA5A5A5A5, 0, 3, 0, 0, 0);
    #1 chk("wr_same_cycle", 64'(rs2_data_o), BYP ? 64'hA5A5A5A5 : 64'h1);
    tick(); drive(0, 0, 0, 0, 3, 0, 0, 0);
    #1 chk("wr_next_cycle", 64'(rs2_data_o), 64'hA5A5A5A5);

    // read-after-write hazard on r7
    tick(); drive(0, 0, 0, 7, 0, 1, 7, 0);
    #1 chk("haz_issue_cycle", 64'(stall_o), 64'd0);
    tick(); drive(0, 0, 0, 7, 0, 0, 0, 0);
    #1 chk("haz_stall1", 64'(stall_o), 64'd1);
    tick();
    #1 chk("haz_stall2", 64'(stall_o), 64'd1);
    tick(); drive(1, 7, 32'h77, 7, 0, 0, 0, 0);
    #1;
    chk("haz_wb_stall", 64'(stall_o), BYP ? 64'd0 : 64'd1);
    chk("haz_wb_data", 64'(rs1_data_o), BYP ? 64'h77 : 64'h0);
    tick(); drive(0, 0, 0, 7, 0, 0, 0, 0);
    #1;
    chk("haz_after_stall", 64'(stall_o), 64'd0);
    chk("haz_after_data", 64'(rs1_data_o), 64'h77);

    // issue and write-back to r9 in the same cycle
    tick(); drive(1, 9, 32'h99, 9, 0, 1, 9, 0);
    #1 chk("sim_data_same", 64'(rs1_data_o), BYP ? 64'h99 : 64'h0);
    tick(); drive(0, 0, 0, 9, 0, 0, 0, 0);
    #1;
    chk("sim_pend9", 64'(pending_o[9]), 64'd1);
    chk("sim_stall", 64'(stall_o), 64'd1);
    chk("sim_data", 64'(rs1_data_o), 64'h99);

    // flush with simultaneous issue and write-back
    tick(); drive(0, 0, 0, 0, 0, 1, 2, 0);
    tick(); drive(0, 0, 0, 0, 0, 1, 4, 0);
    tick(); drive(0, 0, 0, 0, 0, 1, 6, 0);
    tick(); drive(1, 4, 32'h44, 0, 0, 1, 8, 1);
    #1 chk("fl_pre_pend", 64'(pending_o), 64'((N'(1) << 2) | (N'(1) << 4) | (N'(1) << 6) | (N'(1) << 9)));
    tick(); drive(0, 0, 0, 8, 4, 0, 0, 0);
    #1;
    chk("fl_pend", 64'(pending_o), 64'd0);
    chk("fl_stall", 64'(stall_o), 64'd0);
    chk("fl_data", 64'(rs2_data_o), 64'h44);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
            int'($urandom_range(0, 7)), int'($urandom_range(0, N - 1)),
            1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 40) == 0));
      #1;
      a1 = int'(rs1_addr_i);
      a2 = int'(rs2_addr_i);
      d  = int'(destination_i);
      f1 = BYP && wreg_i && d != 0 && d == a1;
      f2 = BYP && wreg_i && d != 0 && d == a2;
      e1 = (a1 == 0) ? 32'h0 : (f1 ? datareg_i : m_regs[a1]);
      e2 = (a2 == 0) ? 32'h0 : (f2 ? datareg_i : m_regs[a2]);
      es = (m_pend[a1] && !f1) || (m_pend[a2] && !f2);
      for (int k = 0; k < N; k++) exp_pend[k] = m_pend[k];
      chk("rnd_rs1", 64'(rs1_data_o), 64'(e1));
      chk("rnd_rs2", 64'(rs2_data_o), 64'(e2));
      chk("rnd_stall", 64'(stall_o), 64'(es));
      chk("rnd_pend", 64'(pending_o), 64'(exp_pend));
      // apply this edge's architectural effects
      if (wreg_i && d != 0) m_regs[d] = datareg_i;
      if (flush_i) begin
        for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
      end else begin
        if (wreg_i) m_pend[d] = 1'b0;
        if (issue_i && issue_dest_i != 0) m_pend[int'(issue_dest_i)] = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
